conv2_relu_maxpool: RTL and testbench

- Downstream of the second-convolution channel calculators. Consumes one channel's signed convolution sum stream (14-bit, row-major, qualified by a valid strobe).
- Adds a per-channel bias, applies ReLU and saturation, then performs 2x2 max pooling with stride 2.
- Emits one unsigned pooled pixel per 2x2 window to the flatten/fully-connected stage.
- One instance per conv2 output channel.

---
 rtl/conv2_relu_maxpool.sv | 147 ++++++++++++++
 tb/tb_conv2_relu_maxpool.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_relu_maxpool.sv
// conv2_relu_maxpool
// Conditions one conv2 channel's signed sum stream (bias, ReLU, saturation)
// and reduces it with 2x2 / stride-2 max pooling. One pooled unsigned pixel
// is emitted per window, one cycle after the window's fourth sample.
module conv2_relu_maxpool #(
    parameter int                 IN_W     = 8,
    parameter int                 IN_H     = 8,
    parameter int                 IN_BITS  = 14,
    parameter int                 OUT_BITS = 12,
    parameter logic signed [7:0]  BIAS     = 8'sd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [IN_BITS-1:0]  conv_in,
    output logic [OUT_BITS-1:0] data_out,
    output logic                valid_out,
    output logic                frame_done
);

    // Widths derived from the geometry; single-bit minimum keeps tiny maps legal.
    localparam int COL_W  = (IN_W > 1)     ? $clog2(IN_W)     : 1;
    localparam int ROW_W  = (IN_H > 1)     ? $clog2(IN_H)     : 1;
    localparam int BUF_N  = IN_W / 2;
    localparam int BUF_AW = (BUF_N > 1)    ? $clog2(BUF_N)    : 1;
    localparam int SUM_W  = IN_BITS + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);
    localparam logic signed [SUM_W-1:0] SAT_S = SUM_W'((1 << OUT_BITS) - 1);

    // Geometry and width sanity, rejected while the design is elaborated.
    if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_in_w
        $error("conv2_relu_maxpool: IN_W must be even and at least 2");
    end
    if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_in_h
        $error("conv2_relu_maxpool: IN_H must be even and at least 2");
    end
    if (SUM_W < 9 || OUT_BITS >= SUM_W) begin : g_bad_widths
        $error("conv2_relu_maxpool: IN_BITS must be >= 8 and OUT_BITS < IN_BITS+1");
    end

    // Unsigned max of two conditioned samples.
    function automatic logic [OUT_BITS-1:0] umax(input logic [OUT_BITS-1:0] a,
                                                  input logic [OUT_BITS-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // State
    logic [COL_W-1:0]    col_q,   col_d;
    logic [ROW_W-1:0]    row_q,   row_d;
    logic [OUT_BITS-1:0] hold_q,  hold_d;
    logic [OUT_BITS-1:0] data_q,  data_d;
    logic                valid_q, valid_d;
    logic                frame_q, frame_d;

    logic [OUT_BITS-1:0] rowbuf_q [BUF_N];
    logic                buf_we;
    logic [BUF_AW-1:0]   buf_idx;
    logic [OUT_BITS-1:0] buf_rd;

    logic signed [SUM_W-1:0] sum_s;
    logic [OUT_BITS-1:0]     sample_v;

    // Sign-extend the sum and the bias into one guard bit so the add cannot overflow.
    assign sum_s   = SUM_W'($signed(conv_in)) + SUM_W'(BIAS);
    assign buf_idx = BUF_AW'(col_q >> 1);
    assign buf_rd  = rowbuf_q[buf_idx];

    // ReLU then clamp to the unsigned output range.
    always_comb begin
        // NOTE: every always_comb output is given a value before any branch, so no latch can be inferred.
        sample_v = '0;
        if (sum_s[SUM_W-1]) begin
            sample_v = '0;
        end else if (sum_s > SAT_S) begin
            sample_v = '1;
        end else begin
            sample_v = sum_s[OUT_BITS-1:0];
        end
    end

    // Raster counters and pooling decisions for the accepted sample.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        data_d  = data_q;
        valid_d = 1'b0;
        frame_d = 1'b0;
        buf_we  = 1'b0;

        if (valid_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            // Parity of (row, col) picks the position inside the 2x2 window.
            case ({row_q[0], col_q[0]})
                2'b00:   hold_d = sample_v;
                2'b01:   buf_we = 1'b1;
                2'b10:   hold_d = umax(buf_rd, sample_v);
                default: begin
                    data_d  = umax(hold_q, sample_v);
                    valid_d = 1'b1;
                    frame_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
                end
            endcase
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
        end
    end

    // Row buffer: pairwise max of the even row, consumed on the following odd row.
    always_ff @(posedge clk) begin
        // NOTE: the row buffer has no reset; each entry is written on an even row before the odd row reads it.
        if (!rst && buf_we) begin
            rowbuf_q[buf_idx] <= umax(hold_q, sample_v);
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_conv2_relu_maxpool.sv
// Testbench for conv2_relu_maxpool: three instances (bias 0, +127, -4) are
// driven with directed and random streams; a frame-image reference model
// computes each pooled pixel straight from the 2x2 window it covers.
module tb_conv2_relu_maxpool;

    localparam int W = 8;
    localparam int H = 8;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a   [NDUT];
    logic        valid_a [NDUT];
    logic [13:0] conv_a  [NDUT];
    logic [11:0] data_a  [NDUT];
    logic        vout_a  [NDUT];
    logic        fd_a    [NDUT];

    int bias_of [NDUT] = '{0, 127, -4};

    conv2_relu_maxpool #(.IN_W(W), .IN_H(H), .IN_BITS(14), .OUT_BITS(12), .BIAS(8'sd0)) u_dut0 (
        .clk(clk), .rst(rst_a[0]), .valid_in(valid_a[0]), .conv_in(conv_a[0]),
        .data_out(data_a[0]), .valid_out(vout_a[0]), .frame_done(fd_a[0]));

    conv2_relu_maxpool #(.IN_W(W), .IN_H(H), .IN_BITS(14), .OUT_BITS(12), .BIAS(8'sd127)) u_dut_sat (
        .clk(clk), .rst(rst_a[1]), .valid_in(valid_a[1]), .conv_in(conv_a[1]),
        .data_out(data_a[1]), .valid_out(vout_a[1]), .frame_done(fd_a[1]));

    conv2_relu_maxpool #(.IN_W(W), .IN_H(H), .IN_BITS(14), .OUT_BITS(12), .BIAS(-8'sd4)) u_dut_neg (
        .clk(clk), .rst(rst_a[2]), .valid_in(valid_a[2]), .conv_in(conv_a[2]),
        .data_out(data_a[2]), .valid_out(vout_a[2]), .frame_done(fd_a[2]));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: raster position, frame image, last emitted pixel.
    int mrow [NDUT];
    int mcol [NDUT];
    int img  [NDUT][H][W];
    int last_data [NDUT];

    int outs[$];
    int fd_count;

    int ramp_exp [16] = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};

    function automatic int cond(input int x, input int bias);
        int s;
        s = x + bias;
        if (s < 0)    return 0;
        if (s > 4095) return 4095;
        return s;
    endfunction

    function automatic int rnd14();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    // One clock of stimulus on DUT d, then compare its outputs to the model.
    task automatic drive_cycle(input int d, input bit v, input int x);
        bit          exp_v;
        bit          exp_fd;
        logic [31:0] xv;
        int          r, c, e;
        exp_v  = 1'b0;
        exp_fd = 1'b0;
        xv     = x;
        valid_a[d] = v;
        conv_a[d]  = xv[13:0];
        if (v) begin
            r = mrow[d];
            c = mcol[d];
            img[d][r][c] = cond(x, bias_of[d]);
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                e = img[d][r-1][c-1];
                if (img[d][r-1][c] > e) e = img[d][r-1][c];
                if (img[d][r][c-1] > e) e = img[d][r][c-1];
                if (img[d][r][c]   > e) e = img[d][r][c];
                exp_v  = 1'b1;
                exp_fd = (r == H-1) && (c == W-1);
                last_data[d] = e;
            end
            mcol[d] = c + 1;
            if (mcol[d] == W) begin
                mcol[d] = 0;
                mrow[d] = (r == H-1) ? 0 : r + 1;
            end
        end
        @(posedge clk);
        #1;
        valid_a[d] = 1'b0;
        n_checks++;
        if (vout_a[d] !== exp_v) begin
            n_fail++;
            $display("FAIL valid_out dut%0d t=%0t: got %b expected %b", d, $time, vout_a[d], exp_v);
        end
        n_checks++;
        if (fd_a[d] !== exp_fd) begin
            n_fail++;
            $display("FAIL frame_done dut%0d t=%0t: got %b expected %b", d, $time, fd_a[d], exp_fd);
        end
        n_checks++;
        if (data_a[d] !== 12'(last_data[d])) begin
            n_fail++;
            $display("FAIL data_out dut%0d t=%0t: got %0d expected %0d", d, $time, data_a[d], last_data[d]);
        end
        if (vout_a[d] === 1'b1) outs.push_back(int'(data_a[d]));
        if (fd_a[d] === 1'b1) fd_count++;
    endtask

    // One reset cycle with valid_in held high (it must be ignored).
    task automatic reset_dut(input int d);
        rst_a[d]   = 1'b1;
        valid_a[d] = 1'b1;
        conv_a[d]  = 14'($urandom);
        @(posedge clk);
        #1;
        rst_a[d]   = 1'b0;
        valid_a[d] = 1'b0;
        mrow[d] = 0;
        mcol[d] = 0;
        last_data[d] = 0;
        n_checks++;
        if (vout_a[d] !== 1'b0 || fd_a[d] !== 1'b0 || data_a[d] !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: got valid=%b fd=%b data=%0d expected 0/0/0",
                     d, vout_a[d], fd_a[d], data_a[d]);
        end
    endtask

    task automatic clear_log();
        outs.delete();
        fd_count = 0;
    endtask

    task automatic check_ramp_outputs(input string name, input int base);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (base + i >= outs.size()) begin
                n_fail++;
                $display("FAIL %s missing output %0d: got none expected %0d", name, i, ramp_exp[i]);
            end else if (outs[base + i] != ramp_exp[i]) begin
                n_fail++;
                $display("FAIL %s output %0d: got %0d expected %0d", name, i, outs[base + i], ramp_exp[i]);
            end
        end
    endtask

    task automatic check_counts(input string name, input int n_out, input int n_fd);
        n_checks++;
        if (outs.size() != n_out) begin
            n_fail++;
            $display("FAIL %s output count: got %0d expected %0d", name, outs.size(), n_out);
        end
        n_checks++;
        if (fd_count != n_fd) begin
            n_fail++;
            $display("FAIL %s frame_done count: got %0d expected %0d", name, fd_count, n_fd);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            reset_dut(d);
            drive_cycle(d, 1'b0, 0);
        end
    endtask

    task automatic test_ramp();
        clear_log();
        for (int k = 0; k < 64; k++) drive_cycle(0, 1'b1, k);
        check_counts("ramp", 16, 1);
        check_ramp_outputs("ramp", 0);
    endtask

    task automatic test_all_negative();
        clear_log();
        for (int k = 0; k < 64; k++) drive_cycle(0, 1'b1, -100);
        check_counts("all_negative", 16, 1);
        foreach (outs[i]) begin
            n_checks++;
            if (outs[i] != 0) begin
                n_fail++;
                $display("FAIL all_negative output %0d: got %0d expected 0", i, outs[i]);
            end
        end
    endtask

    task automatic test_saturation_bias();
        int frame [64];
        int base [4] = '{5, -3, 2, 7};
        // Bias +127 on a near-full-scale window saturates at 4095.
        foreach (frame[i]) frame[i] = rnd14();
        frame[0] = 8191;
        frame[1] = 0;
        frame[8] = 0;
        frame[9] = 0;
        clear_log();
        for (int k = 0; k < 64; k++) drive_cycle(1, 1'b1, frame[k]);
        check_counts("saturation", 16, 1);
        n_checks++;
        if (outs.size() < 1 || outs[0] != 4095) begin
            n_fail++;
            $display("FAIL saturation first window: got %0d expected 4095", (outs.size() > 0) ? outs[0] : -1);
        end
        // Bias -4: the window maximum rotated through all four positions.
        foreach (frame[i]) frame[i] = rnd14();
        for (int w = 0; w < 4; w++) begin
            frame[2*w]         = base[(0 + w) % 4];
            frame[2*w + 1]     = base[(1 + w) % 4];
            frame[8 + 2*w]     = base[(2 + w) % 4];
            frame[8 + 2*w + 1] = base[(3 + w) % 4];
        end
        clear_log();
        for (int k = 0; k < 64; k++) drive_cycle(2, 1'b1, frame[k]);
        check_counts("bias_neg", 16, 1);
        for (int w = 0; w < 4; w++) begin
            n_checks++;
            if (w >= outs.size() || outs[w] != 3) begin
                n_fail++;
                $display("FAIL bias_neg rotation %0d: got %0d expected 3", w, (w < outs.size()) ? outs[w] : -1);
            end
        end
    endtask

    task automatic test_gapped();
        clear_log();
        for (int k = 0; k < 64; k++) begin
            drive_cycle(0, 1'b1, k);
            drive_cycle(0, 1'b0, rnd14());
        end
        check_counts("gapped", 16, 1);
        check_ramp_outputs("gapped", 0);
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 20; k++) drive_cycle(0, 1'b1, k);
        reset_dut(0);
        drive_cycle(0, 1'b0, 0);
        clear_log();
        for (int k = 0; k < 64; k++) drive_cycle(0, 1'b1, k);
        check_counts("reset_mid_frame", 16, 1);
        check_ramp_outputs("reset_mid_frame", 0);
    endtask

    task automatic test_back_to_back();
        clear_log();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 64; k++) drive_cycle(0, 1'b1, k);
        end
        check_counts("back_to_back", 32, 2);
        check_ramp_outputs("back_to_back", 0);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i + 16 >= outs.size() || outs[i + 16] != outs[i]) begin
                n_fail++;
                $display("FAIL back_to_back second frame %0d: got %0d expected %0d",
                         i, (i + 16 < outs.size()) ? outs[i + 16] : -1, (i < outs.size()) ? outs[i] : -1);
            end
        end
    endtask

    task automatic test_random_gaps();
        int sent;
        for (int d = 0; d < NDUT; d += 2) begin
            clear_log();
            sent = 0;
            while (sent < 128) begin
                if ($urandom_range(0, 9) < 7) begin
                    drive_cycle(d, 1'b1, rnd14());
                    sent++;
                end else begin
                    drive_cycle(d, 1'b0, rnd14());
                end
            end
            check_counts("random_gaps", 32, 2);
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_a[d]   = 1'b1;
            valid_a[d] = 1'b0;
            conv_a[d]  = '0;
            mrow[d] = 0;
            mcol[d] = 0;
            last_data[d] = 0;
        end
        fd_count = 0;
        #1;
        test_reset();
        test_ramp();
        test_all_negative();
        test_saturation_bias();
        test_gapped();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
